// File: rtl/rom_pkg.sv
// Shared constants and types for the six-bank ROM loader and its register files.
package rom_pkg;

  localparam int unsigned B1_AW_DEF = 4;
  localparam int unsigned BQ_AW_DEF = 2;
  localparam int unsigned B6_AW_DEF = 3;

  localparam int unsigned B1_DW = 8;
  localparam int unsigned BQ_DW = 4;
  localparam int unsigned B6_DW = 8;

  localparam int unsigned RD_W  = 32;
  localparam int unsigned PTR_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_B1,
    LOAD_BQ,
    LOAD_B6,
    DONE
  } ld_state_t;

endpackage

// File: rtl/rom_bank_rf.sv
// Small register-file bank: synchronous write, asynchronous read, cleared by synchronous reset.
module rom_bank_rf #(
  parameter int unsigned AW = 2,
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/rom_bank_loader.sv
// Streams a byte image into six lookup banks, then serves a registered 32-bit
// concatenated read of all six banks.
module rom_bank_loader
  import rom_pkg::*;
#(
  parameter int unsigned B1_AW = B1_AW_DEF,
  parameter int unsigned BQ_AW = BQ_AW_DEF,
  parameter int unsigned B6_AW = B6_AW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [7:0]      s_data,
  output logic            busy,
  output logic            loaded,
  input  logic            rd_en,
  input  logic [B1_AW-1:0] a1,
  input  logic [BQ_AW-1:0] a2,
  input  logic [BQ_AW-1:0] a3,
  input  logic [BQ_AW-1:0] a4,
  input  logic [BQ_AW-1:0] a5,
  input  logic [B6_AW-1:0] a6,
  output logic [RD_W-1:0] rd_data,
  output logic            rd_valid
);

  localparam int unsigned IMG_LEN = 2 ** B1_AW + 4 * 2 ** BQ_AW + 2 ** B6_AW;

  localparam logic [PTR_W-1:0] B1_LAST = PTR_W'(2 ** B1_AW - 1);
  localparam logic [PTR_W-1:0] BQ_LAST = PTR_W'(4 * 2 ** BQ_AW - 1);
  localparam logic [PTR_W-1:0] B6_LAST = PTR_W'(2 ** B6_AW - 1);

  ld_state_t        state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             loaded_q, loaded_d;
  logic [RD_W-1:0]  rd_data_q;
  logic             rd_valid_q;

  logic       beat;
  logic       b1_we, b6_we;
  logic [3:0] bq_we;
  logic [1:0] bq_sel;

  logic [B1_DW-1:0] b1_rd;
  logic [B6_DW-1:0] b6_rd;
  logic [BQ_DW-1:0] bq_rd [4];
  logic [BQ_AW-1:0] bq_ra [4];

  assign s_ready = (state_q == LOAD_B1) || (state_q == LOAD_BQ) || (state_q == LOAD_B6);
  assign busy    = s_ready;
  assign beat    = s_valid & s_ready;
  assign bq_sel  = ptr_q[BQ_AW +: 2];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    loaded_d = loaded_q;
    b1_we    = 1'b0;
    b6_we    = 1'b0;
    bq_we    = '0;
    // A restart pre-empts any beat presented in the same cycle.
    if (start) begin
      state_d  = LOAD_B1;
      ptr_d    = '0;
      loaded_d = 1'b0;
    end else if (beat) begin
      ptr_d = ptr_q + 1'b1;
      unique case (state_q)
        LOAD_B1: begin
          b1_we = 1'b1;
          if (ptr_q == B1_LAST) begin
            state_d = LOAD_BQ;
            ptr_d   = '0;
          end
        end
        LOAD_BQ: begin
          bq_we[bq_sel] = 1'b1;
          if (ptr_q == BQ_LAST) begin
            state_d = LOAD_B6;
            ptr_d   = '0;
          end
        end
        LOAD_B6: begin
          b6_we = 1'b1;
          if (ptr_q == B6_LAST) begin
            state_d  = DONE;
            ptr_d    = '0;
            loaded_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      loaded_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      loaded_q   <= loaded_d;
      rd_valid_q <= rd_en & loaded_q;
      if (rd_en && loaded_q) begin
        rd_data_q <= {b1_rd, bq_rd[0], bq_rd[1], bq_rd[2], bq_rd[3], b6_rd};
      end
    end
  end

  assign loaded   = loaded_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  always_comb begin
    bq_ra[0] = a2;
    bq_ra[1] = a3;
    bq_ra[2] = a4;
    bq_ra[3] = a5;
  end

  rom_bank_rf #(
    .AW(B1_AW),
    .DW(B1_DW)
  ) u_b1 (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (b1_we),
    .waddr(ptr_q[B1_AW-1:0]),
    .wdata(s_data[B1_DW-1:0]),
    .raddr(a1),
    .rdata(b1_rd)
  );

  for (genvar g = 0; g < 4; g++) begin : g_bq
    rom_bank_rf #(
      .AW(BQ_AW),
      .DW(BQ_DW)
    ) u_bq (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (bq_we[g]),
      .waddr(ptr_q[BQ_AW-1:0]),
      .wdata(s_data[BQ_DW-1:0]),
      .raddr(bq_ra[g]),
      .rdata(bq_rd[g])
    );
  end

  rom_bank_rf #(
    .AW(B6_AW),
    .DW(B6_DW)
  ) u_b6 (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (b6_we),
    .waddr(ptr_q[B6_AW-1:0]),
    .wdata(s_data[B6_DW-1:0]),
    .raddr(a6),
    .rdata(b6_rd)
  );

  if (IMG_LEN > 40) begin : g_img_len_unused
  end

endmodule

// File: tb/tb_rom_bank_loader.sv
// Directed self-checking bench for rom_bank_loader.
module tb_rom_bank_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        busy;
  logic        loaded;
  logic        rd_en;
  logic [3:0]  a1;
  logic [1:0]  a2, a3, a4, a5;
  logic [2:0]  a6;
  logic [31:0] rd_data;
  logic        rd_valid;

  int checks;
  int failures;

  rom_bank_loader u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .busy    (busy),
    .loaded  (loaded),
    .rd_en   (rd_en),
    .a1      (a1),
    .a2      (a2),
    .a3      (a3),
    .a4      (a4),
    .a5      (a5),
    .a6      (a6),
    .rd_data (rd_data),
    .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input logic [7:0] base, input int n, input bit incr);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = incr ? base + 8'(i) : base;
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic set_addr(input logic [3:0] x1, input logic [1:0] x2, input logic [1:0] x3,
                          input logic [1:0] x4, input logic [1:0] x5, input logic [2:0] x6);
    a1 = x1; a2 = x2; a3 = x3; a4 = x4; a5 = x5; a6 = x6;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; rd_en = 1'b0;
    set_addr(4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0);
    tick();
    tick();
    check_eq("rst_s_ready", 32'(s_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_loaded", 32'(loaded), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rd_data", rd_data, 32'h0);
    rst_n = 1'b1;

    // 1: read while not loaded is ignored
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_eq("unloaded_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("unloaded_rd_data", rd_data, 32'h0);

    // 2: gapless image 0x10+i
    pulse_start();
    check_eq("ld_busy", 32'(busy), 32'd1);
    check_eq("ld_s_ready", 32'(s_ready), 32'd1);
    check_eq("ld_loaded", 32'(loaded), 32'd0);
    send_bytes(8'h10, 40, 1'b1);
    check_eq("img_loaded", 32'(loaded), 32'd1);
    check_eq("img_busy", 32'(busy), 32'd0);
    set_addr(4'd1, 2'd0, 2'd0, 2'd0, 2'd0, 3'd3);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_eq("rd1_valid", 32'(rd_valid), 32'd1);
    check_eq("rd1_data", rd_data, 32'h1104_8C33);
    tick();
    check_eq("rd1_pulse", 32'(rd_valid), 32'd0);
    check_eq("rd1_hold", rd_data, 32'h1104_8C33);

    // back-to-back reads
    rd_en = 1'b1;
    set_addr(4'd15, 2'd3, 2'd3, 2'd3, 2'd3, 3'd7);
    tick();
    check_eq("b2b0_valid", 32'(rd_valid), 32'd1);
    check_eq("b2b0_data", rd_data, 32'h1F37_BF37);
    set_addr(4'd0, 2'd1, 2'd1, 2'd1, 2'd1, 3'd0);
    tick();
    rd_en = 1'b0;
    check_eq("b2b1_valid", 32'(rd_valid), 32'd1);
    check_eq("b2b1_data", rd_data, 32'h1015_9D30);

    // 3: same image with s_valid toggled every other cycle
    pulse_start();
    check_eq("tog_loaded_clr", 32'(loaded), 32'd0);
    for (int i = 0; i < 40; i++) begin
      s_valid = 1'b1;
      s_data  = 8'h10 + 8'(i);
      tick();
      s_valid = 1'b0;
      if (i < 39) begin
        check_eq("tog_not_loaded", 32'(loaded), 32'd0);
        tick();
      end
    end
    check_eq("tog_loaded", 32'(loaded), 32'd1);
    set_addr(4'd1, 2'd0, 2'd0, 2'd0, 2'd0, 3'd3);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_eq("tog_rd_data", rd_data, 32'h1104_8C33);

    // 4: restart after 21 beats, then full image of 0xA5
    pulse_start();
    send_bytes(8'h00, 21, 1'b0);
    check_eq("part_busy", 32'(busy), 32'd1);
    check_eq("part_loaded", 32'(loaded), 32'd0);
    pulse_start();
    send_bytes(8'hA5, 40, 1'b0);
    check_eq("a5_loaded", 32'(loaded), 32'd1);
    set_addr(4'd7, 2'd3, 2'd3, 2'd3, 2'd3, 3'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_eq("a5_rd_data", rd_data, 32'hA555_55A5);

    // start coincident with read in DONE: read completes on old contents
    set_addr(4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0);
    start = 1'b1;
    rd_en = 1'b1;
    tick();
    start = 1'b0;
    rd_en = 1'b0;
    check_eq("st_rd_valid", 32'(rd_valid), 32'd1);
    check_eq("st_rd_data", rd_data, 32'hA555_55A5);
    check_eq("st_loaded", 32'(loaded), 32'd0);
    check_eq("st_busy", 32'(busy), 32'd1);

    // 5: start coincident with a beat drops the byte and rewinds ptr
    send_bytes(8'h01, 3, 1'b1);
    start = 1'b1;
    s_valid = 1'b1;
    s_data = 8'hEE;
    tick();
    start = 1'b0;
    s_valid = 1'b0;
    check_eq("sb_busy", 32'(busy), 32'd1);
    check_eq("sb_loaded", 32'(loaded), 32'd0);
    send_bytes(8'h10, 39, 1'b1);
    check_eq("sb_39_not_loaded", 32'(loaded), 32'd0);
    send_bytes(8'h37, 1, 1'b0);
    check_eq("sb_40_loaded", 32'(loaded), 32'd1);
    set_addr(4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_eq("sb_rd_data", rd_data, 32'h1004_8C30);

    // 6: reset mid LOAD_BQ
    pulse_start();
    send_bytes(8'h10, 20, 1'b1);
    check_eq("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("mr_s_ready", 32'(s_ready), 32'd0);
    check_eq("mr_busy", 32'(busy), 32'd0);
    check_eq("mr_loaded", 32'(loaded), 32'd0);
    check_eq("mr_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("mr_rd_data", rd_data, 32'h0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_eq("mr_rd_ignored_valid", 32'(rd_valid), 32'd0);
    check_eq("mr_rd_ignored_data", rd_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
